// File: rtl/sonar_serial_pkg.sv
// sonar_serial_pkg: ASCII constants, frame length and state encodings for the sonar serial receiver
package sonar_serial_pkg;
    localparam logic [6:0] ASCII_ZERO      = 7'h30;
    localparam logic [6:0] ASCII_NOVE      = 7'h39;
    localparam logic [6:0] ASCII_VIRGULA   = 7'h2C;
    localparam logic [6:0] ASCII_CERQUILHA = 7'h23;
    localparam int FRAME_LEN = 8;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DADOS, RX_PARIDADE, RX_STOP} rx_state_t;
    typedef enum logic [3:0] {P_ESPERA, P_A2, P_A1, P_A0, P_VIRG, P_D2, P_D1, P_D0, P_FIM} ps_state_t;
endpackage

// File: rtl/sonar_serial_rx_if.sv
// sonar_serial_rx_if: serial line in, parsed angle/distance and status out
interface sonar_serial_rx_if;
    logic        entrada_serial;
    logic [11:0] angulo;
    logic [11:0] medida;
    logic        pronto;
    logic        erro_paridade;
    logic        erro_formato;
    logic [3:0]  db_estado;
    modport master (output entrada_serial, input angulo, medida, pronto, erro_paridade, erro_formato, db_estado);
    modport slave  (input entrada_serial, output angulo, medida, pronto, erro_paridade, erro_formato, db_estado);
endinterface

// File: rtl/rx_serial_7e1.sv
// rx_serial_7e1: synchroniser, bit timer and 7E1 UART receiver FSM
module rx_serial_7e1 #(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_CNT        = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx_i,
    output logic [6:0] char_o,
    output logic       byte_ok_o,
    output logic       parity_ok_o,
    output logic       stop_err_o
);
    import sonar_serial_pkg::*;
    localparam logic [N_CNT-1:0] HALF = N_CNT'(CLKS_PER_BIT / 2 - 1);
    localparam logic [N_CNT-1:0] LAST = N_CNT'(CLKS_PER_BIT - 1);
    rx_state_t        st_q, st_d;
    logic [N_CNT-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic [6:0]       dat_q, dat_d;
    logic             par_q, par_d;
    logic [1:0]       sync_q;
    logic             prev_q;
    logic             rx, fall, bit_end;
    assign rx          = sync_q[1];
    assign fall        = prev_q & ~rx;
    assign bit_end     = cnt_q == LAST;
    assign char_o      = dat_q;
    assign parity_ok_o = ~^{par_q, dat_q};
    // synchroniser and receiver state registers; line presets to idle-high
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            prev_q <= 1'b1;
            st_q   <= RX_IDLE;
            cnt_q  <= '0;
            idx_q  <= '0;
            dat_q  <= '0;
            par_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], rx_i};
            prev_q <= rx;
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            dat_q  <= dat_d;
            par_q  <= par_d;
        end
    end
    // next state: sample mid-start, then each bit one period later; back to IDLE at mid-stop
    always_comb begin
        st_d       = st_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        dat_d      = dat_q;
        par_d      = par_q;
        byte_ok_o  = 1'b0;
        stop_err_o = 1'b0;
        case (st_q)
            RX_IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                st_d  = fall ? RX_START : RX_IDLE;
            end
            RX_START: if (cnt_q == HALF) begin
                cnt_d = '0;
                st_d  = rx ? RX_IDLE : RX_DADOS;
            end
            RX_DADOS: if (bit_end) begin
                cnt_d = '0;
                dat_d = {rx, dat_q[6:1]};
                idx_d = idx_q + 1'b1;
                st_d  = idx_q == 3'd6 ? RX_PARIDADE : RX_DADOS;
            end
            RX_PARIDADE: if (bit_end) begin
                cnt_d = '0;
                par_d = rx;
                st_d  = RX_STOP;
            end
            RX_STOP: if (bit_end) begin
                cnt_d      = '0;
                st_d       = RX_IDLE;
                byte_ok_o  = rx;
                stop_err_o = ~rx;
            end
            default: st_d = RX_IDLE;
        endcase
    end
endmodule

// File: rtl/sonar_serial_rx.sv
// sonar_serial_rx: parses "AAA,DDD#" frames from a 7E1 UART into BCD angle/distance; SONAR_RX_PARITY_EN enables parity checking
module sonar_serial_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int N_CNT        = 9
) (
    input logic         clock,
    input logic         reset,
    sonar_serial_rx_if.slave bus
);
    import sonar_serial_pkg::*;
    localparam int SH_W = (FRAME_LEN - 2) * 4;
    logic [6:0]      ch;
    logic            byte_ok, par_ok, stop_err, par_fail, dig, ok;
    ps_state_t       st_q, st_d;
    logic [SH_W-1:0] sh_q, sh_d;
    logic            bad_q, bad_d, pronto_q, pronto_d, ep_q, ep_d, ef_q, ef_d;
    logic [11:0]     ang_q, ang_d, med_q, med_d;
    rx_serial_7e1 #(.CLKS_PER_BIT(CLKS_PER_BIT), .N_CNT(N_CNT)) u_rx (
        .clock       (clock),
        .reset       (reset),
        .rx_i        (bus.entrada_serial),
        .char_o      (ch),
        .byte_ok_o   (byte_ok),
        .parity_ok_o (par_ok),
        .stop_err_o  (stop_err)
    );
`ifdef SONAR_RX_PARITY_EN
    assign par_fail = byte_ok & ~par_ok;
`else
    assign par_fail = 1'b0 & par_ok;
`endif
    assign dig               = ch >= ASCII_ZERO && ch <= ASCII_NOVE;
    assign bus.angulo        = ang_q;
    assign bus.medida        = med_q;
    assign bus.pronto        = pronto_q;
    assign bus.erro_paridade = ep_q;
    assign bus.erro_formato  = ef_q;
    assign bus.db_estado     = st_q;
    // parser state, digit shadow and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q     <= P_ESPERA;
            sh_q     <= '0;
            bad_q    <= 1'b0;
            ang_q    <= '0;
            med_q    <= '0;
            pronto_q <= 1'b0;
            ep_q     <= 1'b0;
            ef_q     <= 1'b0;
        end else begin
            st_q     <= st_d;
            sh_q     <= sh_d;
            bad_q    <= bad_d;
            ang_q    <= ang_d;
            med_q    <= med_d;
            pronto_q <= pronto_d;
            ep_q     <= ep_d;
            ef_q     <= ef_d;
        end
    end
    // digits shift into the shadow in arrival order, so a full frame leaves {A2,A1,A0,D2,D1,D0}
    always_comb begin
        st_d     = st_q;
        sh_d     = sh_q;
        bad_d    = bad_q | par_fail;
        ang_d    = ang_q;
        med_d    = med_q;
        pronto_d = 1'b0;
        ep_d     = ep_q | par_fail;
        ef_d     = ef_q;
        ok       = st_q == P_VIRG ? ch == ASCII_VIRGULA : st_q == P_FIM ? ch == ASCII_CERQUILHA : dig;
        if (stop_err) begin
            st_d  = P_ESPERA;
            bad_d = 1'b0;
            ef_d  = 1'b1;
        end else if (byte_ok) begin
            if (!ok) begin
                st_d  = P_ESPERA;
                bad_d = 1'b0;
                ef_d  = ef_q | (st_q != P_ESPERA);
            end else if (st_q == P_FIM) begin
                st_d  = P_ESPERA;
                bad_d = 1'b0;
                if (!(bad_q | par_fail)) begin
                    ang_d    = sh_q[23:12];
                    med_d    = sh_q[11:0];
                    pronto_d = 1'b1;
                    ep_d     = 1'b0;
                    ef_d     = 1'b0;
                end
            end else begin
                st_d = st_q == P_ESPERA ? P_A1 : ps_state_t'(st_q + 4'd1);
                sh_d = st_q == P_VIRG ? sh_q : {sh_q[SH_W-5:0], ch[3:0]};
                if (st_q == P_ESPERA) bad_d = par_fail;
            end
        end
    end
endmodule
